// File: rtl/draw_pkg.sv
// Shared types and constants for the draw sequencer: FSM state encoding,
// default screen/sprite geometry and the pixel totals of each draw mode.
package draw_pkg;

  localparam int SCREEN_W_DEF  = 160;
  localparam int SCREEN_H_DEF  = 120;
  localparam int SPRITE_W_DEF  = 40;

  localparam int SCREEN_PIXELS = 19200;
  localparam int SPRITE_PIXELS = 1600;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAW  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } drawState_e;

endpackage

// File: rtl/draw_sequencer_if.sv
// Request/pixel bus between a draw requester and the draw sequencer.
// Handshake: drawReq is a request that the sequencer takes only on a rising
// edge where busy=0; the request fields (drawSprite, drawImage, drawBlack,
// spriteX, spriteY) are captured on that same edge. While busy=1 requests
// are dropped, never queued. done pulses for one cycle when a draw ends.
// On the pixel side, plot/x/y lag romAddr by one cycle to match ROM latency.
interface draw_sequencer_if;

  logic        drawReq;
  logic        drawSprite;
  logic [6:0]  drawImage;
  logic        drawBlack;
  logic [7:0]  spriteX;
  logic [6:0]  spriteY;

  logic [14:0] romAddr;
  logic [6:0]  memorySel;
  logic        black;
  logic [7:0]  x;
  logic [6:0]  y;
  logic        plot;
  logic        busy;
  logic        done;

  modport master (
    output drawReq, drawSprite, drawImage, drawBlack, spriteX, spriteY,
    input  romAddr, memorySel, black, x, y, plot, busy, done
  );

  modport slave (
    input  drawReq, drawSprite, drawImage, drawBlack, spriteX, spriteY,
    output romAddr, memorySel, black, x, y, plot, busy, done
  );

endinterface

// File: rtl/draw_pixel_counter.sv
// Raster col/row counter. The wrap limits are chosen on load (screen or
// sprite size) and last flags the final pixel of the raster.
module draw_pixel_counter #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int SPRITE_W = 40
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       load,
  input  logic       useSprite,
  input  logic       advance,
  output logic [7:0] col,
  output logic [6:0] row,
  output logic       last
);

  logic [7:0] colMax;
  logic [6:0] rowMax;

  // Load clears position and picks limits; advance steps in raster order and
  // parks on the last pixel.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      col    <= '0;
      row    <= '0;
      colMax <= '0;
      rowMax <= '0;
    end else if (load) begin
      col    <= '0;
      row    <= '0;
      colMax <= useSprite ? 8'(SPRITE_W - 1) : 8'(SCREEN_W - 1);
      rowMax <= useSprite ? 7'(SPRITE_W - 1) : 7'(SCREEN_H - 1);
    end else if (advance && !last) begin
      if (col == colMax) begin
        col <= '0;
        row <= row + 7'd1;
      end else begin
        col <= col + 8'd1;
      end
    end
  end

  assign last = (col == colMax) && (row == rowMax);

endmodule

// File: rtl/draw_sequencer.sv
// Draw sequencer: walks a full screen or a square sprite in raster order,
// issuing one ROM address per cycle and the matching VGA plot one cycle
// later. Optional feature macro DRAW_CLIP_EN suppresses plots of sprite
// pixels that fall off screen (addressing and timing are unaffected).
module draw_sequencer
  import draw_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter int SPRITE_W = SPRITE_W_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  draw_sequencer_if.slave  bus,
  output drawState_e       stateDbg
);

  drawState_e  state, nextState;
  logic        accept;
  logic        advance;

  logic        spriteL;
  logic [7:0]  spriteXL;
  logic [6:0]  spriteYL;

  logic [14:0] romAddrQ;
  logic [6:0]  memorySelQ;
  logic        blackQ;
  logic [7:0]  xQ;
  logic [6:0]  yQ;
  logic        plotQ;

  logic [7:0]  col;
  logic [6:0]  row;
  logic        last;

  logic [7:0]  pixX;
  logic [6:0]  pixY;
  logic        pixOn;

  draw_pixel_counter #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H),
    .SPRITE_W (SPRITE_W)
  ) u_counter (
    .clk       (clk),
    .resetn    (resetn),
    .load      (accept),
    .useSprite (bus.drawSprite),
    .advance   (advance),
    .col       (col),
    .row       (row),
    .last      (last)
  );

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= nextState;
  end

  // Next-state logic: accept only from IDLE, leave DRAW after the last pixel.
  always_comb begin
    nextState = state;
    accept    = 1'b0;
    advance   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.drawReq) begin
          accept    = 1'b1;
          nextState = DRAW;
        end
      end
      DRAW: begin
        advance = 1'b1;
        if (last) nextState = FLUSH;
      end
      FLUSH:   nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Screen coordinates of the pixel currently addressed (8/7-bit wrap).
  always_comb begin
    pixX = spriteL ? (spriteXL + col) : col;
    pixY = spriteL ? (spriteYL + row) : row;
  end

`ifdef DRAW_CLIP_EN
  logic [8:0] fullX;
  logic [7:0] fullY;
  assign fullX = {1'b0, spriteXL} + {1'b0, col};
  assign fullY = {1'b0, spriteYL} + {1'b0, row};
  assign pixOn = !spriteL ||
                 ((fullX <= 9'(SCREEN_W - 1)) && (fullY <= 8'(SCREEN_H - 1)));
`else
  assign pixOn = 1'b1;
`endif

  // Request capture, address generation and the one-cycle-late pixel output.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      spriteL    <= 1'b0;
      spriteXL   <= '0;
      spriteYL   <= '0;
      romAddrQ   <= '0;
      memorySelQ <= '0;
      blackQ     <= 1'b0;
      xQ         <= '0;
      yQ         <= '0;
      plotQ      <= 1'b0;
    end else begin
      plotQ <= (state == DRAW) && pixOn;
      if (accept) begin
        spriteL    <= bus.drawSprite;
        spriteXL   <= bus.spriteX;
        spriteYL   <= bus.spriteY;
        memorySelQ <= bus.drawImage;
        blackQ     <= bus.drawBlack;
        romAddrQ   <= '0;
      end else if (state == DRAW) begin
        if (!last) romAddrQ <= romAddrQ + 15'd1;
        xQ <= pixX;
        yQ <= pixY;
      end
    end
  end

  assign bus.romAddr   = romAddrQ;
  assign bus.memorySel = memorySelQ;
  assign bus.black     = blackQ;
  assign bus.x         = xQ;
  assign bus.y         = yQ;
  assign bus.plot      = plotQ;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign stateDbg      = state;

endmodule

// File: tb/tb_draw_sequencer.sv
// Bench for draw_sequencer: a raster model builds the expected pixel stream
// per draw; a monitor compares every plot, select and done against it.
module tb_draw_sequencer;
  import draw_pkg::*;

  logic       clk = 1'b0;
  logic       resetn;
  drawState_e stateDbg;

  draw_sequencer_if bus();

  draw_sequencer dut (
    .clk      (clk),
    .resetn   (resetn),
    .bus      (bus),
    .stateDbg (stateDbg)
  );

  // Clock and reset block
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [29:0] exp_q[$];
  logic [29:0] pixE;
  logic [6:0]  expSel = '0;
  logic        expBlack = 1'b0;
  bit          drawActive = 1'b0;
  int          expPlots = 0;
  int          plotCount = 0;
  int          doneCount = 0;
  int          cyc = 0;
  logic [14:0] prevAddr = '0;
  logic [7:0]  firstX, lastX;
  logic [6:0]  firstY, lastY;
  logic [14:0] lastAddr;
  int          doneBefore;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_romAddr"},   32'(bus.romAddr),   0);
    check({tag, "_memorySel"}, 32'(bus.memorySel), 0);
    check({tag, "_black"},     32'(bus.black),     0);
    check({tag, "_x"},         32'(bus.x),         0);
    check({tag, "_y"},         32'(bus.y),         0);
    check({tag, "_plot"},      32'(bus.plot),      0);
    check({tag, "_busy"},      32'(bus.busy),      0);
    check({tag, "_done"},      32'(bus.done),      0);
    check({tag, "_state"},     32'(stateDbg),      32'(IDLE));
  endtask

  // Model: the pixels a draw must plot, in raster order, with their address.
  task automatic startDraw(input bit spr, input logic [6:0] img, input bit blk,
                           input int sx, input int sy, input int nPlot);
    int w, h, px, py;
    bit on;
    w = spr ? 40 : 160;
    h = spr ? 40 : 120;
    exp_q.delete();
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        px = spr ? sx + c : c;
        py = spr ? sy + r : r;
        on = 1'b1;
`ifdef DRAW_CLIP_EN
        if (spr && (px > 159 || py > 119)) on = 1'b0;
`endif
        if (on) exp_q.push_back({15'(r * w + c), 8'(px % 256), 7'(py % 128)});
      end
    end
    expSel     = img;
    expBlack   = blk;
    expPlots   = nPlot;
    plotCount  = 0;
    drawActive = 1'b1;
    tick();
    bus.drawSprite = spr;
    bus.drawImage  = img;
    bus.drawBlack  = blk;
    bus.spriteX    = 8'(sx);
    bus.spriteY    = 7'(sy);
    bus.drawReq    = 1'b1;
    tick();
    cyc = 1;
    bus.drawReq    = 1'b0;
    bus.drawSprite = ~spr;
    bus.drawImage  = 7'($urandom_range(0, 127));
    bus.drawBlack  = ~blk;
    bus.spriteX    = 8'($urandom_range(0, 255));
    bus.spriteY    = 7'($urandom_range(0, 127));
    check("busy_after_accept", 32'(bus.busy), 1);
    check("romAddr_first", 32'(bus.romAddr), 0);
  endtask

  task automatic waitDone(input int n);
    while (!bus.done && cyc < n + 50) tick();
    check("done_cycle", cyc, n + 2);
    tick();
    check("busy_after_done", 32'(bus.busy), 0);
    check("plot_after_done", 32'(bus.plot), 0);
    check("romAddr_hold", 32'(bus.romAddr), 32'(lastAddr));
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (resetn) begin
      if (bus.plot) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_plot: got plot at x=%0d y=%0d, expected none", bus.x, bus.y);
        end else begin
          pixE = exp_q.pop_front();
          check("pixel_addr", 32'(prevAddr), 32'(pixE[29:15]));
          check("pixel_x",    32'(bus.x),    32'(pixE[14:7]));
          check("pixel_y",    32'(bus.y),    32'(pixE[6:0]));
          if (plotCount == 0) begin
            firstX = bus.x;
            firstY = bus.y;
          end
          lastX    = bus.x;
          lastY    = bus.y;
          lastAddr = prevAddr;
          plotCount++;
        end
      end
      if (bus.busy) begin
        check("memorySel", 32'(bus.memorySel), 32'(expSel));
        check("black",     32'(bus.black),     32'(expBlack));
      end
      if (bus.done) begin
        if (!drawActive) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1, expected 0");
        end else begin
          check("plot_count",  plotCount, expPlots);
          check("queue_empty", exp_q.size(), 0);
          check("plot_in_done", 32'(bus.plot), 0);
        end
        drawActive = 1'b0;
        doneCount++;
      end
    end
    prevAddr = bus.romAddr;
  end

  // Directed stimulus
  initial begin
    resetn         = 1'b0;
    bus.drawReq    = 1'b0;
    bus.drawSprite = 1'b0;
    bus.drawImage  = '0;
    bus.drawBlack  = 1'b0;
    bus.spriteX    = '0;
    bus.spriteY    = '0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    resetn = 1'b1;
    repeat (2) tick();

    // Full screen, image 5
    startDraw(1'b0, 7'd5, 1'b0, 0, 0, 19200);
    waitDone(19200);
    check("full_first_x", 32'(firstX), 0);
    check("full_first_y", 32'(firstY), 0);
    check("full_last_x", 32'(lastX), 159);
    check("full_last_y", 32'(lastY), 119);
    check("full_last_addr", 32'(lastAddr), 19199);
    check("full_memorySel", 32'(bus.memorySel), 5);

    // Sprite at (60,40)
    startDraw(1'b1, 7'd2, 1'b0, 60, 40, 1600);
    waitDone(1600);
    check("spr_first_x", 32'(firstX), 60);
    check("spr_first_y", 32'(firstY), 40);
    check("spr_last_x", 32'(lastX), 99);
    check("spr_last_y", 32'(lastY), 79);
    check("spr_last_addr", 32'(lastAddr), 1599);

    // Sprite hanging off the bottom-right corner
`ifdef DRAW_CLIP_EN
    startDraw(1'b1, 7'd6, 1'b0, 140, 100, 400);
    waitDone(1600);
    check("clip_last_x", 32'(lastX), 159);
    check("clip_last_y", 32'(lastY), 119);
    check("clip_last_addr", 32'(lastAddr), 779);
`else
    startDraw(1'b1, 7'd6, 1'b0, 140, 100, 1600);
    waitDone(1600);
    check("wrap_last_x", 32'(lastX), 179);
    check("wrap_last_y", 32'(lastY), 11);
    check("wrap_last_addr", 32'(lastAddr), 1599);
`endif

    // Request while busy is dropped
    doneBefore = doneCount;
    startDraw(1'b1, 7'd3, 1'b0, 10, 20, 1600);
    repeat (300) tick();
    bus.drawReq    = 1'b1;
    bus.drawImage  = 7'd9;
    bus.drawSprite = 1'b0;
    tick();
    bus.drawReq = 1'b0;
    waitDone(1600);
    repeat (30) tick();
    check("busy_req_done_count", doneCount, doneBefore + 1);
    check("busy_req_memorySel", 32'(bus.memorySel), 3);

    // Reset in the middle of a full-screen draw
    startDraw(1'b0, 7'd7, 1'b0, 0, 0, 19200);
    repeat (4999) tick();
    #2 resetn = 1'b0;
    #1 checkAllZero("abort");
    exp_q.delete();
    drawActive = 1'b0;
    doneBefore = doneCount;
    repeat (3) tick();
    checkAllZero("abort_hold");
    resetn = 1'b1;
    repeat (10) tick();
    check("abort_no_done", doneCount, doneBefore);
    startDraw(1'b1, 7'd4, 1'b0, 0, 0, 1600);
    waitDone(1600);
    check("post_reset_last_addr", 32'(lastAddr), 1599);

    // Black full-screen fill
    startDraw(1'b0, 7'd1, 1'b1, 0, 0, 19200);
    waitDone(19200);
    check("black_held", 32'(bus.black), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
